// File: rtl/lif_spike_unit.sv
// Leaky integrate-and-fire stage: integrates signed current into a leaky
// membrane, fires with a refractory hold, and reports a windowed rate error.
module lif_spike_unit #(
  parameter logic signed [31:0] THRESHOLD      = 32'sd1000000,
  parameter int                 LEAK_SHIFT     = 4,
  parameter int                 REFRACT_CYCLES = 4,
  parameter int                 WINDOW         = 64,
  parameter int                 TARGET_SPIKES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               in_valid,
  input  logic signed [31:0] in_current,
  output logic               spike,
  output logic signed [31:0] membrane_potential,
  output logic [1:0]         state,
  output logic signed [15:0] feedback_error,
  output logic               error_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    REFR  = 2'd2
  } state_t;

  localparam int WW = $clog2(WINDOW);
  localparam int RW = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;

  localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
  localparam logic [RW-1:0] RLOAD = RW'(REFRACT_CYCLES - 1);

  localparam logic signed [33:0] TH   = 34'(THRESHOLD);
  localparam logic signed [33:0] VMIN = -TH;
  localparam logic signed [33:0] VMAX = 34'sd2147483647;
  localparam logic signed [33:0] TGT  = 34'(TARGET_SPIKES);

  state_t             state_q;
  logic signed [31:0] v_q;
  logic               spike_q;
  logic signed [15:0] err_q;
  logic               errv_q;
  logic [RW-1:0]      rcnt_q;
  logic [WW-1:0]      wcnt_q;
  logic [15:0]        scnt_q;

  logic signed [33:0] v_ext;
  logic signed [33:0] leak;
  logic signed [33:0] cur;
  logic signed [33:0] s_raw;
  logic signed [33:0] s_d;
  logic               fire;
  logic [16:0]        cnt_tot;
  logic signed [33:0] diff;
  logic signed [15:0] err_d;
  logic [15:0]        scnt_d;

  always_comb begin
    v_ext = 34'(v_q);
    leak  = v_ext >>> LEAK_SHIFT;
    cur   = in_valid ? 34'(in_current) : '0;
    s_raw = v_ext - leak + cur;
    if (s_raw < VMIN)
      s_d = VMIN;
    else if (s_raw > VMAX)
      s_d = VMAX;
    else
      s_d = s_raw;
    fire = (state_q == INTEG) && (s_d >= TH);
  end

  // A fire in the last window cycle still belongs to the closing window.
  always_comb begin
    cnt_tot = {1'b0, scnt_q} + {16'b0, fire};
    diff    = TGT - $signed({17'b0, cnt_tot});
    if (diff > 34'sd32767)
      err_d = 16'sh7FFF;
    else if (diff < -34'sd32768)
      err_d = 16'sh8000;
    else
      err_d = diff[15:0];
    scnt_d = (scnt_q == 16'hFFFF || !fire) ? scnt_q : scnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      spike_q <= 1'b0;
      err_q   <= '0;
      errv_q  <= 1'b0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
      v_q     <= '0;
      spike_q <= 1'b0;
      errv_q  <= 1'b0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      spike_q <= 1'b0;
      errv_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q <= INTEG;
          v_q     <= '0;
        end
        INTEG: begin
          if (fire) begin
            spike_q <= 1'b1;
            v_q     <= '0;
            rcnt_q  <= RLOAD;
            state_q <= REFR;
          end else begin
            v_q <= s_d[31:0];
          end
        end
        REFR: begin
          v_q <= '0;
          if (rcnt_q == '0)
            state_q <= INTEG;
          else
            rcnt_q <= rcnt_q - RW'(1);
        end
        default: state_q <= IDLE;
      endcase
      if (state_q != IDLE) begin
        if (wcnt_q == WLAST) begin
          wcnt_q <= '0;
          scnt_q <= '0;
          err_q  <= err_d;
          errv_q <= 1'b1;
        end else begin
          wcnt_q <= wcnt_q + WW'(1);
          scnt_q <= scnt_d;
        end
      end
    end
  end

  assign spike              = spike_q;
  assign membrane_potential = v_q;
  assign state              = state_q;
  assign feedback_error     = err_q;
  assign error_valid        = errv_q;

endmodule

// File: tb/tb_lif_spike_unit.sv
// Bench for lif_spike_unit: directed vectors, a behavioural model compared
// every cycle, and hand-computed literal expectations.
module tb_lif_spike_unit;

  localparam longint TH  = 1000000;
  localparam int     LS  = 4;
  localparam int     REF = 4;
  localparam int     WIN = 64;
  localparam int     TGT = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [31:0] in_current = '0;
  logic               spike;
  logic signed [31:0] membrane_potential;
  logic [1:0]         state;
  logic signed [15:0] feedback_error;
  logic               error_valid;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  lif_spike_unit dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .in_valid           (in_valid),
    .in_current         (in_current),
    .spike              (spike),
    .membrane_potential (membrane_potential),
    .state              (state),
    .feedback_error     (feedback_error),
    .error_valid        (error_valid)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 integrate, 2 refractory.
  int     m_mode = 0;
  longint m_v    = 0;
  int     m_spk  = 0;
  longint m_err  = 0;
  int     m_ev   = 0;
  int     m_left = 0;
  int     m_pos  = 0;
  int     m_cnt  = 0;

  always @(posedge clk) begin
    longint s;
    int f;
    if (rst) begin
      m_mode = 0; m_v = 0; m_spk = 0; m_err = 0;
      m_ev = 0; m_left = 0; m_pos = 0; m_cnt = 0;
    end else if (!enable) begin
      m_mode = 0; m_v = 0; m_spk = 0; m_ev = 0;
      m_left = 0; m_pos = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_v = 0; m_spk = 0; m_ev = 0;
    end else begin
      f = 0;
      m_pos = m_pos + 1;
      if (m_mode == 1) begin
        s = m_v - (m_v >>> LS) + (in_valid ? longint'(in_current) : 0);
        if (s < -TH) s = -TH;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s >= TH) begin
          f = 1; m_v = 0; m_mode = 2; m_left = REF;
        end else begin
          m_v = s;
        end
      end else begin
        m_v = 0;
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 1;
      end
      m_spk = f;
      if (f == 1 && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_pos == WIN) begin
        s = TGT - m_cnt;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        m_err = s; m_ev = 1; m_cnt = 0; m_pos = 0;
      end else begin
        m_ev = 0;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_spike", longint'(spike), longint'(m_spk));
      chk("m_v", longint'(membrane_potential), m_v);
      chk("m_state", longint'(state), longint'(m_mode));
      chk("m_err", longint'(feedback_error), m_err);
      chk("m_ev", longint'(error_valid), longint'(m_ev));
    end
  end

  task automatic drive(input logic r, input logic e, input logic vld,
                       input logic signed [31:0] c);
    rst = r; enable = e; in_valid = vld; in_current = c;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint exp_v [5];
    exp_v = '{200000, 387500, 563282, 728077, 882573};
    @(negedge clk);

    // Reset state
    drive(1, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_state", longint'(state), 0);
    chk("rst_v", longint'(membrane_potential), 0);
    chk("rst_spike", longint'(spike), 0);
    chk("rst_fe", longint'(feedback_error), 0);
    chk("rst_ev", longint'(error_valid), 0);

    // Constant current
    drive(0, 1, 1, 200000);
    chk("cc_idle_exit", longint'(state), 1);
    for (int i = 1; i <= 64; i++) begin
      drive(0, 1, 1, 200000);
      if (i <= 5) chk("cc_v", longint'(membrane_potential), exp_v[i-1]);
      chk("cc_spike", longint'(spike), (i % 10 == 6) ? 1 : 0);
      if (i == 6) chk("cc_refr", longint'(state), 2);
      if (i == 64) begin
        chk("cc_ev", longint'(error_valid), 1);
        chk("cc_fe", longint'(feedback_error), -2);
      end
    end

    // Silence
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 1; i <= 64; i++) begin
      drive(0, 1, 0, 0);
      chk("sil_spike", longint'(spike), 0);
      chk("sil_ev", longint'(error_valid), (i == 64) ? 1 : 0);
    end
    chk("sil_fe", longint'(feedback_error), 4);

    // Negative clamp then max positive fire
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 32'sh80000000);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 32'sh80000000);
      chk("clamp_v", longint'(membrane_potential), -1000000);
    end
    drive(0, 1, 1, 32'sh7FFFFFFF);
    chk("clamp_fire", longint'(spike), 1);
    chk("clamp_v0", longint'(membrane_potential), 0);

    // Fire on the last window cycle
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 1; i <= 63; i++) drive(0, 1, 0, 0);
    drive(0, 1, 1, 32'sd1000000);
    chk("wb_spike", longint'(spike), 1);
    chk("wb_ev", longint'(error_valid), 1);
    chk("wb_fe", longint'(feedback_error), 3);
    for (int i = 1; i <= 64; i++) drive(0, 1, 0, 0);
    chk("wb_next_ev", longint'(error_valid), 1);
    chk("wb_next_fe", longint'(feedback_error), 4);

    // Enable drop during refractory
    drive(0, 1, 1, 32'sd1000000);
    chk("ed_fire", longint'(spike), 1);
    drive(0, 1, 0, 0);
    chk("ed_refr", longint'(state), 2);
    drive(0, 0, 0, 0);
    chk("ed_idle", longint'(state), 0);
    chk("ed_v", longint'(membrane_potential), 0);
    chk("ed_ev", longint'(error_valid), 0);
    chk("ed_fe", longint'(feedback_error), 4);
    drive(0, 1, 0, 0);
    for (int i = 1; i <= 64; i++) begin
      drive(0, 1, 0, 0);
      chk("ed_win_ev", longint'(error_valid), (i == 64) ? 1 : 0);
    end
    chk("ed_win_fe", longint'(feedback_error), 4);

    // Reset mid-integration
    drive(0, 1, 1, 32'sd500000);
    chk("rm_v", longint'(membrane_potential), 500000);
    drive(1, 1, 1, 32'sd1000000);
    chk("rm_state", longint'(state), 0);
    chk("rm_v0", longint'(membrane_potential), 0);
    chk("rm_spike", longint'(spike), 0);
    chk("rm_ev", longint'(error_valid), 0);
    chk("rm_fe", longint'(feedback_error), 0);
    drive(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_spike_unit.md
Name: lif_spike_unit

Overview:
Leaky integrate-and-fire stage that sits directly downstream of the plastic neuron. It consumes the neuron's signed 32-bit weighted output as input current and integrates it into a leaky membrane potential. It emits a one-cycle spike when the potential reaches threshold, then enforces a refractory period. Once per fixed observation window it produces a signed 16-bit rate error (target minus actual spikes), which drives the neuron's feedback_error learning input.

Parameters:
THRESHOLD, 32'sd1000000, firing threshold; positive; also sets the negative clamp floor at -THRESHOLD
LEAK_SHIFT, 4, per-cycle leak of v >>> LEAK_SHIFT (arithmetic shift); range 1..15
REFRACT_CYCLES, 4, number of refractory cycles after each spike; must be >= 1
WINDOW, 64, observation window length in active cycles; must be >= 2
TARGET_SPIKES, 4, desired spike count per window

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  run enable; 0 forces IDLE
in_valid  input  1  in_current is valid this cycle
in_current  input  32  signed input current (neuron output_signal)
spike  output  1  one-cycle spike pulse
membrane_potential  output  32  signed membrane register v
state  output  2  0 = IDLE, 1 = INTEGRATE, 2 = REFRACTORY
feedback_error  output  16  signed rate error; holds between updates
error_valid  output  1  one-cycle pulse when feedback_error updates

Behaviour:
- Reset (rst = 1 at clk edge): state = IDLE; spike, membrane_potential, feedback_error and error_valid = 0; refractory counter, window counter and spike counter = 0. rst has priority over all other inputs.
- IDLE: v = 0, spike = 0, and counters are held at 0.
  - enable = 1 → INTEGRATE on the next cycle. The IDLE cycle is not counted in the window.
- enable = 0 in any state → IDLE on the next edge.
  - v, the refractory counter, the window counter and the spike counter are cleared.
  - No error_valid is generated. feedback_error holds its value.
- INTEGRATE, each cycle:
  - Compute s = v - (v >>> LEAK_SHIFT) + (in_valid ? in_current : 0) in at least 34-bit signed arithmetic.
  - Saturate s to [-THRESHOLD, 2^31-1].
  - If s >= THRESHOLD: fire. Registered spike = 1, v = 0, refractory counter = REFRACT_CYCLES-1, and go to REFRACTORY.
  - Otherwise v = s and spike = 0.
- Latency: a sample that causes a fire produces spike high exactly one cycle after it is presented. membrane_potential reflects s, or 0 on a fire, one cycle after the sample.
- REFRACTORY: in_current is ignored, v is held at 0 and spike = 0.
  - The state lasts exactly REFRACT_CYCLES cycles, with the counter decrementing each cycle.
  - When the counter reaches 0 → INTEGRATE.
- Window counter: increments on every INTEGRATE or REFRACTORY cycle, counting 0..WINDOW-1 and then wrapping to 0.
- Spike counter: increments on each fire decision and saturates at 65535.
- On a window counter = WINDOW-1 cycle:
  - feedback_error = sat16(TARGET_SPIKES - (spike count + fire this cycle)).
  - error_valid = 1 for that one cycle.
  - The spike counter resets to 0.
  - A fire in the final window cycle counts toward the closing window, not the next.
- sat16 clamps to [-32768, 32767].
- All outputs are registered.

Test Plan:
- Constant current: rst, then enable = 1, in_valid = 1, in_current = 200000 → v = 200000, 387500, 563282, 728077, 882573, then fire on the 6th sample.
  - spike appears one cycle later.
  - 4 REFRACTORY cycles follow, then the pattern repeats every 10 cycles.
  - Fires occur at window cycles 6, 16, 26, 36, 46 and 56 (window cycles numbered 1..64 from the first INTEGRATE cycle, so the decision is on cycle 6, the same cycle the 6th sample is presented).
  - At window cycle 64: error_valid = 1 and feedback_error = -2 (0xFFFE).
- Silence: enable = 1, in_valid = 0 for 64 cycles → no spikes, v = 0, error_valid on the 64th INTEGRATE cycle with feedback_error = +4.
- Clamp: in_current = 0x80000000 repeatedly → membrane_potential settles at -1000000 and never goes below it; a subsequent in_current = 0x7FFFFFFF fires, with spike the next cycle and v = 0.
- Window-boundary fire: time a fire on window cycle 64 → it is counted in the closing window's error and the next window's count starts at 0.
- Enable drop: deassert enable during REFRACTORY → IDLE next cycle, v = 0, counters cleared, no error_valid, feedback_error unchanged. Re-enable restarts the window from cycle 1.
- Reset mid-integration: rst with v = 500000 → all outputs 0 and state = IDLE on the next edge, with no spike or error_valid pulse.
